counter_updown_limit: RTL and testbench
=======================================

# counter_updown_limit

Parametrised up/down counter with a programmable terminal value, selectable wrap or saturate behaviour and a registered terminal-count pulse. It is the general-purpose successor to the basic set/increment counter and is used for loop indices, burst-length tracking and timeout generation in the datapath and control blocks. Load has priority over counting, as in the existing counter.

## Interface
Parameters:
- width, 8, counter and data width in bits (≥2)
- saturate, 0, 0 = wrap at boundaries, 1 = hold at boundaries

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_set_en  input  1  load i_data into counter
- i_count_en  input  1  perform one count step
- i_down  input  1  step direction: 0 = up (+1), 1 = down (−1); sampled only with i_count_en
- i_data  input  width  load value
- i_limit  input  width  terminal (maximum) value; counting range is 0..i_limit
- number  output  width  current count (registered)
- o_tc  output  1  terminal-count pulse (registered)
- o_at_limit  output  1  combinational: number ≥ i_limit
- o_at_zero  output  1  combinational: number == 0

## Operation
- Reset: asynchronous assertion of rst_n=0 forces number=0 and o_tc=0 immediately; both are held while rst_n=0. Deassertion is synchronous in effect: the first update occurs on the first rising edge with rst_n=1.
- Priority per edge: reset > i_set_en > i_count_en > hold.
- Set: number ← i_data unchanged, even when i_data > i_limit. o_tc ← 0. i_count_en and i_down are ignored in that cycle.
- Up step (i_count_en=1, i_down=0):
  - number < i_limit: number ← number+1, o_tc ← 0.
  - number ≥ i_limit (boundary): wrap mode: number ← 0; saturate mode: number unchanged. o_tc ← 1 in both modes.
- Down step (i_count_en=1, i_down=1):
  - number > 0: number ← number−1, o_tc ← 0. A down step from above i_limit decrements normally.
  - number == 0 (boundary): wrap mode: number ← i_limit; saturate mode: number unchanged at 0. o_tc ← 1 in both modes.
- Idle (no set, no count): number held, o_tc ← 0. o_tc is therefore a single-cycle pulse per boundary step. It stays high continuously only while boundary steps repeat on consecutive cycles, for example under saturation.
- Arithmetic: all width-bit and unsigned. No intermediate overflow is possible because the boundary checks precede the ±1 step. i_limit=0: every up step and every down step is a boundary step, number stays 0, and o_tc=1 after each step.
- i_limit is read live every cycle and is not latched. Changing i_limit below the current number causes the next up step to be a boundary step.
- o_at_limit and o_at_zero are derived combinationally from number and i_limit only and are never registered.

## Timing
- Latency: set or count at edge N → new number and o_tc visible after edge N; flags follow number in the same cycle.
- Throughput: one step per cycle; back-to-back steps and direction changes are allowed on every cycle.
- Reset mid-operation: number and o_tc go to 0 asynchronously, regardless of pending set or count inputs.
- Simultaneous i_set_en and i_count_en: the load wins, no step is taken, and o_tc=0.

## Test plan
- Reset: width=8, drive number to 0x5A, assert rst_n=0 between clock edges → number=0, o_tc=0 before the next edge; hold 3 cycles with i_count_en=1 → stays 0.
- Wrap up: saturate=0, i_limit=9, set 7, then 4 up steps → number 8, 9, 0, 1; o_tc=1 only in the cycle showing 0; o_at_limit=1 only while number=9.
- Wrap down and saturate: saturate=0, i_limit=9, from 1 take 2 down steps → 0, 9, with o_tc=1 with 9. Repeat with saturate=1 → 0, 0, with o_tc high for the second step only, and held high while down steps continue at 0.
- Priority: i_set_en=1, i_count_en=1, i_data=0x33 → number=0x33, o_tc=0. Next cycle, count up with i_limit=0xFF → 0x34.
- Out-of-range load: i_limit=10, set 200, up step → wrap mode gives 0, saturate mode gives 200, o_tc=1 in both. Down step from 200 → 199, o_tc=0.
- i_limit=0 and full range: i_limit=0, 3 up steps → number 0, o_tc=1 each cycle. i_limit=0xFF, set 0xFE, 2 up steps in wrap mode → 0xFF then 0x00, with o_tc=1 on 0x00.

Source files
------------

// File: rtl/counter_updown_limit.sv
// Up/down counter over the range 0..i_limit with wrap or saturate at the
// boundaries, load-over-count priority and a registered terminal-count pulse.
module counter_updown_limit #(
   parameter int width    = 8,
   parameter bit saturate = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_set_en,
   input  logic             i_count_en,
   input  logic             i_down,
   input  logic [width-1:0] i_data,
   input  logic [width-1:0] i_limit,
   output logic [width-1:0] number,
   output logic             o_tc,
   output logic             o_at_limit,
   output logic             o_at_zero
);

   localparam logic [width-1:0] l_one = width'(1);

   logic [width-1:0] r_number;
   logic             r_tc;
   logic [width-1:0] w_next_number;
   logic             w_next_tc;
   logic             w_up_bound;
   logic             w_dn_bound;

   // Boundary tests come before the step, so the +/-1 can never overflow.
   assign w_up_bound = (r_number >= i_limit);
   assign w_dn_bound = (r_number == '0);

   always_comb begin
      w_next_number = r_number;
      w_next_tc     = 1'b0;
      if (i_set_en) begin
         w_next_number = i_data;
      end else if (i_count_en) begin
         if (!i_down) begin
            if (w_up_bound) begin
               w_next_tc     = 1'b1;
               w_next_number = saturate ? r_number : '0;
            end else begin
               w_next_number = r_number + l_one;
            end
         end else begin
            if (w_dn_bound) begin
               w_next_tc     = 1'b1;
               w_next_number = saturate ? '0 : i_limit;
            end else begin
               w_next_number = r_number - l_one;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_number <= '0;
         r_tc     <= 1'b0;
      end else begin
         r_number <= w_next_number;
         r_tc     <= w_next_tc;
      end
   end

   // Flags track the live i_limit and are intentionally left unregistered.
   assign number     = r_number;
   assign o_tc       = r_tc;
   assign o_at_limit = w_up_bound;
   assign o_at_zero  = w_dn_bound;

endmodule

// File: tb/tb_counter_updown_limit.sv
// Bench for counter_updown_limit: a wrap and a saturate instance share stimulus
// and are compared every cycle against an arithmetic reference model.
module tb_counter_updown_limit;

   logic       clk;
   logic       rst_n;
   logic       i_set_en;
   logic       i_count_en;
   logic       i_down;
   logic [7:0] i_data;
   logic [7:0] i_limit;
   logic [7:0] num_w, num_s;
   logic       tc_w, tc_s, lim_w, lim_s, zero_w, zero_s;

   int checks = 0;
   int errors = 0;

   // index 0 = wrap instance, 1 = saturate instance
   logic [7:0] m_num [2];
   logic       m_tc  [2];

   counter_updown_limit #(.width(8), .saturate(1'b0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .i_set_en(i_set_en), .i_count_en(i_count_en),
      .i_down(i_down), .i_data(i_data), .i_limit(i_limit),
      .number(num_w), .o_tc(tc_w), .o_at_limit(lim_w), .o_at_zero(zero_w));

   counter_updown_limit #(.width(8), .saturate(1'b1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .i_set_en(i_set_en), .i_count_en(i_count_en),
      .i_down(i_down), .i_data(i_data), .i_limit(i_limit),
      .number(num_s), .o_tc(tc_s), .o_at_limit(lim_s), .o_at_zero(zero_s));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: counting range is 0..lim, values are plain integers
   function automatic logic [7:0] ref_num(input bit sat, input int cur, input bit s,
                                          input bit c, input bit d, input int data,
                                          input int lim);
      int nxt;
      if (s)       nxt = data;
      else if (!c) nxt = cur;
      else if (!d) nxt = (cur >= lim) ? (sat ? cur : 0) : cur + 1;
      else         nxt = (cur == 0) ? (sat ? 0 : lim) : cur - 1;
      return nxt[7:0];
   endfunction

   function automatic logic ref_tc(input int cur, input bit s, input bit c,
                                   input bit d, input int lim);
      if (s || !c) return 1'b0;
      return d ? (cur == 0) : (cur >= lim);
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("wrap_number", num_w, m_num[0]);
      check("wrap_tc", {7'd0, tc_w}, {7'd0, m_tc[0]});
      check("wrap_at_limit", {7'd0, lim_w}, {7'd0, m_num[0] >= i_limit});
      check("wrap_at_zero", {7'd0, zero_w}, {7'd0, m_num[0] == 8'd0});
      check("sat_number", num_s, m_num[1]);
      check("sat_tc", {7'd0, tc_s}, {7'd0, m_tc[1]});
      check("sat_at_limit", {7'd0, lim_s}, {7'd0, m_num[1] >= i_limit});
      check("sat_at_zero", {7'd0, zero_s}, {7'd0, m_num[1] == 8'd0});
   endtask

   // driver: apply inputs at negedge, advance model at posedge, sample 1 ns later
   task automatic cycle(input bit s, input bit c, input bit d,
                        input logic [7:0] data, input logic [7:0] lim);
      @(negedge clk);
      i_set_en = s; i_count_en = c; i_down = d; i_data = data; i_limit = lim;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_num[k] = 8'd0;
            m_tc[k]  = 1'b0;
         end else begin
            m_tc[k]  = ref_tc(int'(m_num[k]), s, c, d, int'(lim));
            m_num[k] = ref_num(k == 1, int'(m_num[k]), s, c, d, int'(data), int'(lim));
         end
      end
      #1;
      compare_all();
   endtask

   initial begin
      rst_n = 1'b0; i_set_en = 1'b0; i_count_en = 1'b0; i_down = 1'b0;
      i_data = 8'd0; i_limit = 8'hFF;
      m_num[0] = 8'd0; m_num[1] = 8'd0; m_tc[0] = 1'b0; m_tc[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      @(negedge clk); rst_n = 1'b1;

      // asynchronous reset mid-cycle, then held with counting requested
      cycle(1, 0, 0, 8'h5A, 8'hFF);
      check("load_5a", num_w, 8'h5A);
      #2; rst_n = 1'b0; #1;
      m_num[0] = 8'd0; m_num[1] = 8'd0; m_tc[0] = 1'b0; m_tc[1] = 1'b0;
      check("async_rst_number", num_w, 8'd0);
      check("async_rst_tc", {7'd0, tc_w}, 8'd0);
      compare_all();
      repeat (3) cycle(0, 1, 0, 8'd0, 8'hFF);
      @(negedge clk); rst_n = 1'b1;

      // wrap up through limit 9: 8, 9, 0, 1
      cycle(1, 0, 0, 8'd7, 8'd9);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'd0, 8'd9);
      check("wrap_up_end", num_w, 8'd1);

      // down through zero: wrap -> 0, 9; saturate -> 0, 0, 0, 0
      cycle(1, 0, 0, 8'd1, 8'd9);
      for (int i = 0; i < 4; i++) cycle(0, 1, 1, 8'd0, 8'd9);
      check("sat_down_hold_tc", {7'd0, tc_s}, 8'd1);

      // set beats count; then up step with full limit
      cycle(1, 1, 0, 8'h33, 8'hFF);
      check("prio_load", num_w, 8'h33);
      check("prio_tc", {7'd0, tc_w}, 8'd0);
      cycle(0, 1, 0, 8'd0, 8'hFF);
      check("prio_next", num_w, 8'h34);

      // out-of-range load
      cycle(1, 0, 0, 8'd200, 8'd10);
      cycle(0, 1, 0, 8'd0, 8'd10);
      check("oor_wrap", num_w, 8'd0);
      check("oor_sat", num_s, 8'd200);
      cycle(0, 1, 1, 8'd0, 8'd10);
      check("oor_sat_down", num_s, 8'd199);

      // limit 0, then full range wrap
      cycle(1, 0, 0, 8'd0, 8'd0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'd0, 8'd0);
      cycle(0, 1, 1, 8'd0, 8'd0);
      cycle(1, 0, 0, 8'hFE, 8'hFF);
      cycle(0, 1, 0, 8'd0, 8'hFF);
      cycle(0, 1, 0, 8'd0, 8'hFF);
      check("full_wrap", num_w, 8'h00);
      check("full_wrap_tc", {7'd0, tc_w}, 8'd1);

      // randomized traffic, including live limit changes and idle cycles
      for (int i = 0; i < 400; i++) begin
         logic [7:0] lim;
         case ($urandom_range(0, 5))
            0:       lim = 8'd0;
            1:       lim = 8'hFF;
            default: lim = 8'($urandom_range(1, 20));
         endcase
         cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1, 8'($urandom_range(0, 30)), lim);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
